sample_voice_sched: RTL and testbench

SAMPLE_VOICE_SCHED -- requirements
Module: sample_voice_sched

---
 rtl/sound_pkg.sv | 42 ++++
 rtl/voice_channel.sv | 65 ++++++
 rtl/sample_voice_sched.sv | 155 +++++++++++++++
 tb/tb_sample_voice_sched.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sound_pkg.sv
// sound_pkg: constants shared by the sample voice scheduler.
//   - SILENCE            : mid-scale unsigned sample (no output)
//   - MAX_VOICES         : voices addressable from output_latch[7:1]
//   - sched_state_e      : scheduler FSM states
//   - voice_base/len()   : per-voice sample ROM table lookup, per game
package sound_pkg;

    localparam logic [7:0] SILENCE    = 8'h80;
    localparam int         MAX_VOICES = 7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_REQ
    } sched_state_e;

    // Tables have 8 entries so a 3-bit voice index never runs off the end;
    // entry 7 is unreachable from output_latch.
    localparam logic [24:0] BASE_SW [8] = '{
        25'h0100000, 25'h0110000, 25'h0120000, 25'h0130000,
        25'h0140000, 25'h0150000, 25'h0160000, 25'h0170000
    };
    localparam logic [15:0] LEN_SW [8] = '{
        16'd3, 16'd20, 16'd6, 16'd40, 16'd16, 16'd16, 16'd16, 16'd16
    };
    localparam logic [24:0] BASE_RB [8] = '{
        25'h1800000, 25'h1808000, 25'h1810000, 25'h1818000,
        25'h1820000, 25'h1828000, 25'h1830000, 25'h1838000
    };
    localparam logic [15:0] LEN_RB [8] = '{
        16'd5, 16'd9, 16'd4, 16'd4, 16'd4, 16'd4, 16'd4, 16'd4
    };

    function automatic logic [24:0] voice_base(input logic rb, input logic [2:0] v);
        return rb ? BASE_RB[v] : BASE_SW[v];
    endfunction

    function automatic logic [15:0] voice_len(input logic rb, input logic [2:0] v);
        return rb ? LEN_RB[v] : LEN_SW[v];
    endfunction

endpackage

// File: rtl/voice_channel.sv
// voice_channel: per-voice state for the sample scheduler.
//   clk, rst    : clock, synchronous active-high reset
//   trig_i      : level from output_latch; a rising edge (re)starts the voice
//   ack_i       : fetch for this voice completed, data_i holds the byte
//   len_i       : sample length in bytes for the selected game
//   silence_i   : voice was skipped by the scheduler; output goes silent
//   active_o    : voice is playing
//   offset_o    : next byte offset to fetch
//   sample_o    : current output sample
module voice_channel
    import sound_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        trig_i,
    input  logic        ack_i,
    input  logic [7:0]  data_i,
    input  logic [15:0] len_i,
    input  logic        silence_i,
    output logic        active_o,
    output logic [15:0] offset_o,
    output logic [7:0]  sample_o
);

    logic        prev_q;
    logic        active_q;
    logic [15:0] offset_q;
    logic [7:0]  sample_q;
    logic        trig;
    logic        last;

    assign trig = trig_i & ~prev_q;
    assign last = (offset_q == len_i - 16'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            // Edge detector loads the live level so a held bit is not a trigger.
            prev_q   <= trig_i;
            active_q <= 1'b0;
            offset_q <= '0;
            sample_q <= SILENCE;
        end else begin
            prev_q <= trig_i;
            // A retrigger on the final byte keeps the voice alive, so the
            // fetched byte is played instead of silence.
            if (ack_i)
                sample_q <= (last && !trig) ? SILENCE : data_i;
            else if (silence_i)
                sample_q <= SILENCE;
            if (trig) begin
                active_q <= 1'b1;
                offset_q <= '0;
            end else if (ack_i) begin
                offset_q <= offset_q + 16'd1;
                if (last)
                    active_q <= 1'b0;
            end
        end
    end

    assign active_o = active_q;
    assign offset_o = offset_q;
    assign sample_o = sample_q;

endmodule

// File: rtl/sample_voice_sched.sv
// sample_voice_sched: shares one SDRAM read port among NUM_VOICES sample
// voices. Each 48 kHz period, every playing voice fetches one byte, lowest
// voice index first.
//   clk, rst       : clock, synchronous active-high reset
//   clk_48KHz_en   : sample-period strobe
//   mod_redbaron   : game select; disables voices 2 and up
//   output_latch   : bit i+1 rising edge triggers voice i
//   sdram_req/addr : read request, held until sdram_ack
//   sdram_ack/data : one-cycle completion with the byte
//   voice_sample   : 8 bits per voice, voice i at [8i+7:8i]
//   voice_active   : voice playing (and enabled for this game)
//   overrun        : sticky; period overran or a fetch timed out
module sample_voice_sched
    import sound_pkg::*;
#(
    parameter int NUM_VOICES  = 4,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clk_48KHz_en,
    input  logic                    mod_redbaron,
    input  logic [7:0]              output_latch,
    output logic                    sdram_req,
    output logic [24:0]             sdram_addr,
    input  logic                    sdram_ack,
    input  logic [7:0]              sdram_data,
    output logic [8*NUM_VOICES-1:0] voice_sample,
    output logic [NUM_VOICES-1:0]   voice_active,
    output logic                    overrun
);

    localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    sched_state_e          state_q;
    logic [NUM_VOICES-1:0] pending_q;
    logic [VW-1:0]         cur_q;
    logic                  req_q;
    logic [24:0]           addr_q;
    logic [TW-1:0]         tmo_q;
    logic                  overrun_q;

    logic [NUM_VOICES-1:0]        act_raw, en_mask, act_eff, eligible;
    logic [NUM_VOICES-1:0]        skip_vec, ack_vec, cur_1h;
    logic [NUM_VOICES-1:0][15:0]  offset, len_vec;
    logic [NUM_VOICES-1:0][7:0]   sample;
    logic [VW-1:0]                sel_idx;
    logic                         sel_vld;
    logic [24:0]                  scan_addr;
    logic                         ack_hit, tmo_hit;
    logic                         unused_latch;

    assign unused_latch = ^output_latch;

    always_comb begin
        en_mask = '1;
        for (int v = 0; v < NUM_VOICES; v++)
            en_mask[v] = !(mod_redbaron && v >= 2);
    end

    assign act_eff  = act_raw & en_mask;
    assign eligible = pending_q & act_eff;
    // Pending voices that lost their enable or stopped are dropped in SCAN.
    assign skip_vec = (state_q == ST_SCAN) ? (pending_q & ~act_eff) : '0;

    // Lowest-index eligible voice wins.
    always_comb begin
        sel_idx = '0;
        sel_vld = 1'b0;
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (eligible[v]) begin
                sel_vld = 1'b1;
                sel_idx = VW'(v);
            end
        end
    end

    assign scan_addr = voice_base(mod_redbaron, 3'(sel_idx)) + {9'd0, offset[sel_idx]};
    assign cur_1h    = NUM_VOICES'(1) << cur_q;
    assign ack_hit   = (state_q == ST_REQ) && sdram_ack;
    assign tmo_hit   = (state_q == ST_REQ) && !sdram_ack && (tmo_q == TW'(ACK_TIMEOUT - 1));
    assign ack_vec   = ack_hit ? cur_1h : '0;

    for (genvar i = 0; i < NUM_VOICES; i++) begin : g_voice
        assign len_vec[i] = voice_len(mod_redbaron, 3'(i));
        voice_channel u_ch (
            .clk       (clk),
            .rst       (rst),
            .trig_i    (output_latch[i+1]),
            .ack_i     (ack_vec[i]),
            .data_i    (sdram_data),
            .len_i     (len_vec[i]),
            .silence_i (skip_vec[i]),
            .active_o  (act_raw[i]),
            .offset_o  (offset[i]),
            .sample_o  (sample[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            cur_q     <= '0;
            req_q     <= 1'b0;
            addr_q    <= '0;
            tmo_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            // A strobe outside IDLE is dropped; the running period finishes.
            if (clk_48KHz_en && state_q != ST_IDLE)
                overrun_q <= 1'b1;
            case (state_q)
                ST_IDLE: begin
                    if (clk_48KHz_en) begin
                        pending_q <= act_eff;
                        state_q   <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    pending_q <= pending_q & act_eff;
                    if (sel_vld) begin
                        cur_q   <= sel_idx;
                        addr_q  <= scan_addr;
                        req_q   <= 1'b1;
                        tmo_q   <= '0;
                        state_q <= ST_REQ;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (ack_hit || tmo_hit) begin
                        req_q     <= 1'b0;
                        pending_q <= pending_q & ~cur_1h;
                        state_q   <= ST_SCAN;
                        if (tmo_hit)
                            overrun_q <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign sdram_req    = req_q;
    assign sdram_addr   = addr_q;
    assign voice_sample = sample;
    assign voice_active = act_eff;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_sample_voice_sched.sv
module tb_sample_voice_sched;

    localparam int NV  = 4;
    localparam int TMO = 255;

    logic              clk = 1'b0;
    logic              rst, clk_48KHz_en, mod_redbaron, sdram_ack;
    logic [7:0]        output_latch, sdram_data;
    logic              sdram_req;
    logic [24:0]       sdram_addr;
    logic [8*NV-1:0]   voice_sample;
    logic [NV-1:0]     voice_active;
    logic              overrun;

    sample_voice_sched #(.NUM_VOICES(NV), .ACK_TIMEOUT(TMO)) dut (
        .clk          (clk),
        .rst          (rst),
        .clk_48KHz_en (clk_48KHz_en),
        .mod_redbaron (mod_redbaron),
        .output_latch (output_latch),
        .sdram_req    (sdram_req),
        .sdram_addr   (sdram_addr),
        .sdram_ack    (sdram_ack),
        .sdram_data   (sdram_data),
        .voice_sample (voice_sample),
        .voice_active (voice_active),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: what each voice should be doing, by the rules.
    bit         m_act [NV];
    logic [15:0] m_off [NV];
    logic [7:0] m_samp [NV];
    bit         m_ovr;

    function automatic logic [24:0] t_base(input bit rb, input int v);
        return rb ? 25'h1800000 + 25'(v) * 25'h0008000
                  : 25'h0100000 + 25'(v) * 25'h0010000;
    endfunction

    function automatic logic [15:0] t_len(input bit rb, input int v);
        if (rb) begin
            case (v)
                0: return 16'd5;
                1: return 16'd9;
                default: return 16'd4;
            endcase
        end
        case (v)
            0: return 16'd3;
            1: return 16'd20;
            2: return 16'd6;
            default: return 16'd40;
        endcase
    endfunction

    function automatic bit en(input int v);
        return !(mod_redbaron && v >= 2);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int v = 0; v < NV; v++) begin
            m_act[v] = 0; m_off[v] = '0; m_samp[v] = 8'h80;
        end
        m_ovr = 0;
    endtask

    // Change the latch; rising bits start their voice at this clock edge.
    task automatic set_latch(input logic [7:0] val);
        for (int v = 0; v < NV; v++)
            if (val[v+1] && !output_latch[v+1]) begin
                m_act[v] = 1; m_off[v] = '0;
            end
        output_latch = val;
        tick();
    endtask

    // One sample period with an SDRAM responder. delay<0 means never ack.
    task automatic do_period(input int delay, input bit inject, input int retrig_v,
                             input bit flip_rb, input string tag);
        int q[$];
        int cnt;
        logic [7:0] d;
        logic [24:0] ea;
        logic [8*NV-1:0] es;
        logic [NV-1:0] eact;
        for (int v = 0; v < NV; v++)
            if (m_act[v] && en(v)) q.push_back(v);
        clk_48KHz_en = 1; tick(); clk_48KHz_en = 0;
        foreach (q[i]) begin
            int v;
            v = q[i];
            if (!(m_act[v] && en(v))) begin
                m_samp[v] = 8'h80;
                continue;
            end
            tick();
            ea = t_base(mod_redbaron, v) + 25'(m_off[v]);
            checks++;
            if (sdram_req !== 1'b1 || sdram_addr !== ea) begin
                errors++;
                $display("FAIL %s req v%0d: req=%b addr=%h, want req=1 addr=%h", tag, v, sdram_req, sdram_addr, ea);
            end
            if (flip_rb && i == 0) mod_redbaron = ~mod_redbaron;
            if (delay < 0) begin
                cnt = 1;
                for (int k = 0; k < TMO + 8; k++) begin
                    tick();
                    if (sdram_req === 1'b1) cnt++;
                    else break;
                end
                checks++;
                if (cnt != TMO) begin
                    errors++;
                    $display("FAIL %s timeout v%0d: req high %0d cycles, want %0d", tag, v, cnt, TMO);
                end
                m_ovr = 1;
            end else begin
                for (int k = 0; k < delay; k++) begin
                    if (inject && k == delay / 2) clk_48KHz_en = 1;
                    tick();
                    clk_48KHz_en = 0;
                    checks++;
                    if (sdram_req !== 1'b1 || sdram_addr !== ea) begin
                        errors++;
                        $display("FAIL %s hold v%0d: req=%b addr=%h, want req=1 addr=%h", tag, v, sdram_req, sdram_addr, ea);
                    end
                end
                if (inject && delay > 0) m_ovr = 1;
                d = 8'($urandom);
                sdram_ack = 1; sdram_data = d;
                if (retrig_v == v) output_latch[v+1] = 1'b1;
                tick();
                sdram_ack = 0;
                if (retrig_v == v) begin
                    m_act[v] = 1; m_off[v] = '0; m_samp[v] = d;
                end else begin
                    m_samp[v] = d;
                    if (m_off[v] == t_len(mod_redbaron, v) - 16'd1) begin
                        m_act[v] = 0; m_samp[v] = 8'h80;
                    end
                    m_off[v] = m_off[v] + 16'd1;
                end
                checks++;
                if (sdram_req !== 1'b0) begin
                    errors++;
                    $display("FAIL %s req_drop v%0d: req=%b, want 0", tag, v, sdram_req);
                end
            end
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (sdram_req !== 1'b0) begin
                errors++;
                $display("FAIL %s idle_req: req=%b addr=%h, want req=0", tag, sdram_req, sdram_addr);
            end
        end
        for (int v = 0; v < NV; v++) begin
            es[8*v +: 8] = m_samp[v];
            eact[v] = m_act[v] && en(v);
        end
        checks++;
        if (voice_sample !== es || voice_active !== eact || overrun !== m_ovr) begin
            errors++;
            $display("FAIL %s state: samp=%h act=%b ovr=%b, want samp=%h act=%b ovr=%b",
                     tag, voice_sample, voice_active, overrun, es, eact, m_ovr);
        end
    endtask

    task automatic test_reset();
        rst = 1; clk_48KHz_en = 0; mod_redbaron = 0; sdram_ack = 0;
        sdram_data = 8'h00; output_latch = 8'hFE;
        tick(); tick();
        rst = 0;
        model_reset();
        checks++;
        if (sdram_req !== 1'b0 || sdram_addr !== 25'd0) begin
            errors++;
            $display("FAIL reset_req: req=%b addr=%h, want 0/0", sdram_req, sdram_addr);
        end
        checks++;
        if (voice_sample !== {NV{8'h80}}) begin
            errors++;
            $display("FAIL reset_samples: got %h, want all 80", voice_sample);
        end
        checks++;
        if (voice_active !== '0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: act=%b ovr=%b, want 0/0", voice_active, overrun);
        end
        tick(); tick(); tick();
        checks++;
        if (voice_active !== '0) begin
            errors++;
            $display("FAIL reset_no_spurious: act=%b, want 0", voice_active);
        end
        set_latch(8'h00);
    endtask

    task automatic test_single_voice();
        set_latch(8'h02);
        checks++;
        if (voice_active !== 4'b0001) begin
            errors++;
            $display("FAIL single_trigger: act=%b, want 0001", voice_active);
        end
        for (int p = 0; p < 3; p++) do_period(0, 0, -1, 0, "single");
        checks++;
        if (voice_active[0] !== 1'b0 || voice_sample[7:0] !== 8'h80) begin
            errors++;
            $display("FAIL single_end: act0=%b samp0=%h, want 0/80", voice_active[0], voice_sample[7:0]);
        end
        set_latch(8'h00);
    endtask

    task automatic test_two_voices();
        set_latch(8'h0A);
        set_latch(8'h00);
        do_period(1, 0, -1, 0, "two");
    endtask

    task automatic test_overrun();
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun_pre: got %b, want 0", overrun);
        end
        do_period(30, 1, -1, 0, "ovr");
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set: got %b, want 1", overrun);
        end
    endtask

    task automatic test_retrigger();
        set_latch(8'h04);
        set_latch(8'h00);
        do_period(2, 0, -1, 0, "pre_retrig");
        do_period(3, 0, 1, 0, "retrig");
        set_latch(8'h00);
        checks++;
        if (voice_active[1] !== 1'b1 || voice_sample[15:8] !== m_samp[1]) begin
            errors++;
            $display("FAIL retrig_state: act1=%b samp1=%h, want 1/%h", voice_active[1], voice_sample[15:8], m_samp[1]);
        end
        do_period(0, 0, -1, 0, "post_retrig");
    endtask

    task automatic test_skip();
        mod_redbaron = 0;
        set_latch(8'h0A);
        set_latch(8'h00);
        do_period(2, 0, -1, 1, "skip");
        checks++;
        if (voice_sample[23:16] !== 8'h80) begin
            errors++;
            $display("FAIL skip_silence: samp2=%h, want 80", voice_sample[23:16]);
        end
        mod_redbaron = 0;
        tick();
    endtask

    task automatic test_timeout();
        rst = 1; tick(); rst = 0;
        model_reset();
        set_latch(8'h06);
        set_latch(8'h00);
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL timeout_pre: ovr=%b, want 0", overrun);
        end
        do_period(-1, 0, -1, 0, "timeout");
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL timeout_ovr: ovr=%b, want 1", overrun);
        end
        do_period(0, 0, -1, 0, "post_timeout");
    endtask

    task automatic test_reset_mid_fetch();
        clk_48KHz_en = 1; tick(); clk_48KHz_en = 0; tick();
        checks++;
        if (sdram_req !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_req: req=%b, want 1", sdram_req);
        end
        rst = 1; output_latch = 8'h06;
        tick();
        checks++;
        if (sdram_req !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_abort: req=%b, want 0", sdram_req);
        end
        rst = 0;
        model_reset();
        tick();
        sdram_ack = 1; sdram_data = 8'h55;
        tick();
        sdram_ack = 0;
        tick(); tick();
        checks++;
        if (sdram_req !== 1'b0 || voice_sample !== {NV{8'h80}} || voice_active !== '0) begin
            errors++;
            $display("FAIL rstmid_late_ack: req=%b samp=%h act=%b, want 0/all 80/0", sdram_req, voice_sample, voice_active);
        end
        set_latch(8'h00);
    endtask

    task automatic test_random();
        int dl;
        for (int it = 0; it < 40; it++) begin
            mod_redbaron = ($urandom_range(0, 3) == 0);
            set_latch(8'($urandom_range(0, 15)) << 1);
            dl = $urandom_range(0, 4);
            do_period(dl, (dl > 0) && ($urandom_range(0, 7) == 0), -1, 0, "rand");
        end
        mod_redbaron = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_voice();
        test_two_voices();
        test_overrun();
        test_retrigger();
        test_skip();
        test_timeout();
        test_reset_mid_fetch();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
